// File: rtl/rom_port_arbiter.sv
// Arbitrates the shared single-port ID/password ROM between two lookup requesters.
// Requester 0 does user-ID matching and requester 1 does password matching.
// Requests are served one at a time. When both ask at once, round-robin picks the winner.
// The arbiter drives the ROM address, waits out the read latency, captures the word
// and returns it to the owner with a one-cycle valid strobe.
module rom_port_arbiter #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned ROM_LAT = 2   // legal range 1..7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              busy
);

  localparam logic [2:0] CntLast = 3'(ROM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StCapture} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic              busy_q, busy_d;

  // Winner when in idle: on a tie, the requester that did not own the ROM last time.
  logic win;
  logic req_own;
  assign win     = (req0 & req1) ? ~last_q : req1;
  assign req_own = owner_q ? req1 : req0;

  // Next-state and registered-output logic for the grant/wait/capture sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    last_d     = last_q;
    rom_addr_d = rom_addr_q;
    gnt0_d     = gnt0_q;
    gnt1_d     = gnt1_q;
    rdata_d    = rdata_q;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    busy_d     = busy_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          rom_addr_d = win ? addr1 : addr0;
          gnt0_d     = ~win;
          gnt1_d     = win;
          owner_d    = win;
          last_d     = win;
          cnt_d      = 3'd0;
          busy_d     = 1'b1;
          state_d    = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == CntLast) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        // An owner that dropped its request has abandoned it: no data, no strobe.
        if (req_own) begin
          rdata_d   = rom_q;
          rvalid0_d = ~owner_q;
          rvalid1_d = owner_q;
        end
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous active-low reset. Reset favours requester 0 first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      rom_addr_q <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rdata_q    <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      rom_addr_q <= rom_addr_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rdata_q    <= rdata_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      busy_q     <= busy_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign rdata    = rdata_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign busy     = busy_q;

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single-port, registered ID/password ROM between two lookup requesters: requester 0 is user-ID matching and requester 1 is password matching.
- Serialises requests, drives the ROM address, waits out the ROM read latency, captures the ROM word and returns it to the owning requester with a one-cycle valid strobe.
- Round-robin arbitration breaks ties, so neither requester starves.

Parameters:
- ADDR_W, 5, ROM address width.
- DATA_W, 4, ROM data width (one digit per word).
- ROM_LAT, 2, wait cycles between the ROM address register update and the capture of rom_q; legal range 1..7.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-low reset.
- req0  input  1  requester 0 lookup request; held high until rvalid0 or until it abandons the request.
- addr0  input  ADDR_W  requester 0 word address; sampled only at grant.
- req1  input  1  requester 1 lookup request.
- addr1  input  ADDR_W  requester 1 word address.
- rom_addr  output  ADDR_W  registered ROM address.
- rom_q  input  DATA_W  ROM read data.
- gnt0  output  1  high while requester 0 owns the ROM.
- gnt1  output  1  high while requester 1 owns the ROM.
- rdata  output  DATA_W  last captured ROM word; holds its value between captures.
- rvalid0  output  1  one-cycle strobe: rdata is valid for requester 0.
- rvalid1  output  1  one-cycle strobe: rdata is valid for requester 1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst==0 at a clk edge):
  - rom_addr=0, gnt0=gnt1=0, rdata=0, rvalid0=rvalid1=0, busy=0.
  - state=IDLE, wait counter=0, last_owner=1, so requester 0 wins the first tie.
  - Reset mid-transaction aborts it: no rvalid is issued and rdata is not updated.
- All outputs are registered.
- States are IDLE, WAIT and CAPTURE.
- IDLE:
  - No request: stay in IDLE, all strobes low.
  - Only one of req0/req1 high: that requester wins.
  - Both high: winner is the requester that is not last_owner.
  - On the winning edge: rom_addr<=addr_winner, gnt_winner<=1, owner<=winner, last_owner<=winner, cnt<=0, busy<=1, next state WAIT.
- WAIT:
  - cnt increments each cycle.
  - When cnt==ROM_LAT-1, go to CAPTURE.
  - rom_addr and gnt are held stable.
  - Changes on addr0/addr1 are ignored.
- CAPTURE:
  - If req_owner is still high: rdata<=rom_q and rvalid_owner<=1 for exactly one cycle.
  - If req_owner has dropped (abandoned): rdata unchanged, no rvalid.
  - On the same edge: gnt_owner<=0, busy<=0, state IDLE.
- Latency: a request granted at edge T has its data sampled at edge T+ROM_LAT+1. rvalid is high during the following cycle.
- Throughput: at most one transaction per ROM_LAT+2 cycles. A pending request from the other requester is granted on the edge after CAPTURE; IDLE lasts at least one cycle.
- Simultaneous events:
  - A request arriving while busy waits; it is never dropped while held high.
  - The losing requester in a tie is served next if it keeps its request asserted.
- Grants and rvalids are mutually exclusive: gnt0&gnt1 and rvalid0&rvalid1 are never both 1.
- No address range checking; rom_addr wraps naturally at 2^ADDR_W.

Test Plan:
- Single lookup: reset, then req0=1, addr0=5'd4, rom_q returns 4'hA one cycle after rom_addr changes.
  - Expect rom_addr=4 and gnt0 rising at the grant edge T.
  - Expect rdata=4'hA and rvalid0 for one cycle after edge T+3; busy low afterwards.
- Tie and round-robin: req0 and req1 both held high from reset, addr0=1, addr1=9.
  - Expect grant order 0,1,0,1.
  - Expect rom_addr sequence 1,9,1,9, each transaction 4 cycles apart.
  - Never both gnt high.
- Request while busy: req1 asserted during requester 0's WAIT.
  - Expect gnt1 asserted exactly one IDLE cycle after rvalid0.
  - Expect addr1 sampled at that grant, not earlier.
- Abandoned request: req0 dropped during WAIT, rom_q=4'h7.
  - Expect no rvalid0 and rdata to keep its previous value.
  - Expect busy to clear on schedule and the next request to be serviced normally.
- Reset mid-operation: rst=0 in CAPTURE.
  - Expect all outputs 0 on the next edge and no rvalid.
  - After rst=1 with both requests high, expect requester 0 granted first.
- Latency parameter: ROM_LAT=1 and ROM_LAT=4.
  - Expect capture at T+2 and T+5 respectively.
  - Expect rdata to match a model ROM at rom_addr.
